// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end sharing one carry-skip adder, with a
// single-entry result register. Optional grant counters under ADDER_ARBITER_STATS_EN.
module adder_arbiter_csa #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o,
  output logic         ovf_o
);
  localparam int NB = N / 4;

  logic c, cb, pblk, p, g, c_msb;

  always_comb begin
    sum_o = '0;
    c     = cin_i;
    cb    = 1'b0;
    pblk  = 1'b0;
    p     = 1'b0;
    g     = 1'b0;
    c_msb = 1'b0;
    for (int k = 0; k < NB; k++) begin
      cb   = c;
      pblk = 1'b1;
      for (int j = 0; j < 4; j++) begin
        p = a_i[4*k+j] ^ b_i[4*k+j];
        g = a_i[4*k+j] & b_i[4*k+j];
        sum_o[4*k+j] = p ^ c;
        if (4*k+j == N-1) c_msb = c;
        c    = g | (p & c);
        pblk = pblk & p;
      end
      // all-propagate block: carry bypasses the ripple chain
      if (pblk) c = cb;
    end
    cout_o = c;
    ovf_o  = c_msb ^ c;
  end
endmodule

module adder_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req0_cin,
  input  logic         req1_cin,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_sum,
  output logic         resp_cout,
  output logic         resp_overflow
`ifdef ADDER_ARBITER_STATS_EN
  ,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1
`endif
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e       state_q;
  logic         last_grant_q;
  logic         id_q, cout_q, ovf_q;
  logic [N-1:0] sum_q;

  logic         slot_free, gnt_any, gnt_id, accept;
  logic [N-1:0] op_a, op_b, sum_d;
  logic         op_cin, cout_d, ovf_d;

  assign slot_free  = (state_q == EMPTY) || resp_ready;
  assign gnt_any    = req0_valid | req1_valid;
  assign gnt_id     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign accept     = rst_n & slot_free & gnt_any;
  assign req0_ready = accept & ~gnt_id;
  assign req1_ready = accept & gnt_id;

  assign op_a   = gnt_id ? req1_a   : req0_a;
  assign op_b   = gnt_id ? req1_b   : req0_b;
  assign op_cin = gnt_id ? req1_cin : req0_cin;

  adder_arbiter_csa #(.N(N)) u_csa (
    .a_i(op_a), .b_i(op_b), .cin_i(op_cin),
    .sum_o(sum_d), .cout_o(cout_d), .ovf_o(ovf_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (accept) begin
      state_q      <= FULL;
      last_grant_q <= gnt_id;
      id_q         <= gnt_id;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
      ovf_q        <= ovf_d;
    end else if (resp_ready) begin
      state_q      <= EMPTY;
    end
  end

  assign resp_valid    = (state_q == FULL);
  assign resp_id       = id_q;
  assign resp_sum      = sum_q;
  assign resp_cout     = cout_q;
  assign resp_overflow = ovf_q;

`ifdef ADDER_ARBITER_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (req0_ready && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (req1_ready && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif
endmodule
